// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Holds the FSM state codes, the Rcon constants and the GF(2^8) doubling helper.
package aes_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'h0,
        ST_LOADING = 4'h1,
        ST_INIT    = 4'h2,
        ST_ROUND   = 4'h3,
        ST_DONE    = 4'h4
    } aes_ctrl_state_e;

    localparam int         AES128_NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8), reduced by the AES polynomial.
    function automatic logic [7:0] xtime8(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads to 0x01 on clr_i, doubles in GF(2^8) on adv_i.
// One-cycle update; clr_i has priority over adv_i.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (clr_i) begin
            rcon_d = RCON_INIT;
        end else if (adv_i) begin
            rcon_d = xtime8(rcon_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: initial AddRoundKey, NR round strobes, done.
// Control outputs are registered; a rising load aborts any run in progress.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR          = AES128_NR,
    parameter int STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    output logic       init_ld,
    output logic       round_en,
    output logic       last_round,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic [3:0] state
);

    localparam int         SW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [3:0] NR_W     = 4'(NR);

    aes_ctrl_state_e state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic            init_ld_q, round_en_q, last_round_q, busy_q, done_q;
    logic            rcon_clr, rcon_adv;
    logic [7:0]      rcon_r;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_LOADING;
            end
            ST_LOADING: begin
                if (!load) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (load) begin
                    state_d = ST_LOADING;
                end else begin
                    state_d = ST_ROUND;
                    round_d = 4'd1;
                    sub_d   = '0;
                end
            end
            ST_ROUND: begin
                if (load) begin
                    state_d = ST_LOADING;
                    round_d = 4'd0;
                    sub_d   = '0;
                end else if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    if (round_q == NR_W) begin
                        state_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end
            ST_DONE: begin
                if (load) begin
                    state_d = ST_LOADING;
                    round_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
                sub_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            round_q      <= 4'd0;
            sub_q        <= '0;
            init_ld_q    <= 1'b0;
            round_en_q   <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            sub_q        <= sub_d;
            init_ld_q    <= (state_d == ST_INIT);
            round_en_q   <= (state_d == ST_ROUND) && (sub_d == SUB_LAST);
            last_round_q <= (state_d == ST_ROUND) && (round_d == NR_W);
            busy_q       <= (state_d == ST_INIT) || (state_d == ST_ROUND);
            done_q       <= (state_d == ST_DONE);
        end
    end

    // Rcon holds 0x01 until the first round and only advances between non-final rounds.
    assign rcon_clr = (state_q != ST_ROUND);
    assign rcon_adv = (state_q == ST_ROUND) && !load && (sub_q == SUB_LAST) && (round_q != NR_W);

    aes_rcon_gen u_rcon_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (rcon_clr),
        .adv_i   (rcon_adv),
        .rcon_o  (rcon_r)
    );

    assign init_ld    = init_ld_q;
    assign round_en   = round_en_q;
    assign last_round = last_round_q;
    assign rcon       = (state_q == ST_ROUND) ? rcon_r : 8'h00;
    assign round      = round_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Control FSM that sequences the iterative AES-128 encryption datapath inside the AES core. Watches the SPI-side load strobe, issues the initial AddRoundKey, ten round-advance strobes with the matching key-expansion Rcon, and the last-round MixColumns bypass, then raises and holds done. The datapath (state register, round logic, key-expansion register) is purely slave to this block; the FSM state is exported as the 4-bit debug state bus.

Parameters:
NR, 10, number of cipher rounds (AES-128); round counter width fixed at 4 bits, NR must be in 1..15
STEP_CYCLES, 1, clock cycles per round (>=1); allows multi-cycle S-box (e.g. registered EBR lookup)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
load  input  1  high while SPI shifts key/plaintext; falling edge starts encryption
init_ld  output  1  one-cycle: state_reg <= plaintext ^ key, rk_reg <= key
round_en  output  1  one-cycle: state_reg <= round(state_reg, next rk), rk_reg <= expand(rk_reg, rcon)
last_round  output  1  high during the whole final round; datapath skips MixColumns
rcon  output  8  Rcon for the round currently executing; 0x00 outside ROUND
round  output  4  current round number, 0 in IDLE/LOADING/INIT, 1..NR in ROUND, NR in DONE
busy  output  1  high in INIT and ROUND
done  output  1  high in DONE; held until load rises
state  output  4  FSM encoding for debug LEDs/logic analyser

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; round=0, sub-cycle counter=0, rcon register=0x01; all outputs low/zero; state=4'h0.
- State encoding: IDLE=0, LOADING=1, INIT=2, ROUND=3, DONE=4; other codes unreachable, recover to IDLE.
- IDLE: load=1 -> LOADING. load=0 stays IDLE (no start without a prior high load).
- LOADING: stays while load=1; load=0 -> INIT (start = falling edge of load, sampled on clk).
- INIT (exactly one cycle): init_ld=1, busy=1, round=0; next ROUND with round=1, rcon=0x01, sub=0.
- ROUND: busy=1; sub counts 0..STEP_CYCLES-1; round_en=1 only when sub==STEP_CYCLES-1. On that cycle: if round==NR -> DONE; else round+1, sub=0, rcon <= xtime(rcon) = {rcon[6:0],0} ^ (rcon[7] ? 0x1B : 0x00).
- Rcon sequence rounds 1..10: 01 02 04 08 10 20 40 80 1B 36.
- last_round = (FSM==ROUND && round==NR).
- Latency: load falling seen at edge E -> init_ld high cycle E+1 -> first round_en at cycle E+1+STEP_CYCLES -> done high at E+1+NR*STEP_CYCLES+1 (12 cycles after E for defaults).
- DONE: done=1, round held at NR, rcon=0x00. load=1 -> LOADING, done drops that same edge. done stays high indefinitely otherwise.
- Load rising during INIT or ROUND: abort -> LOADING next edge; round, sub cleared, rcon reloaded 0x01; no further round_en; done not asserted.
- load held high through reset release: IDLE -> LOADING next edge; encryption only after subsequent falling edge.
- reset_n asserted mid-operation: immediate return to reset values, no done.
- round_en and init_ld never high in same cycle; at most one of them per cycle.

Decomposition:
- Package aes_ctrl_pkg: FSM state enum (4-bit, codes above), AES128_NR=10, RCON_INIT=8'h01, RCON_POLY=8'h1B, function xtime8.
- One natural sub-module: aes_rcon_gen (8-bit Rcon register with reset/advance inputs). Sub-cycle and round counters stay in the top FSM.

Test Plan:
- Reset: reset_n=0 with load=1 -> all outputs 0, state=0; release, load stays 1 -> state=1, no init_ld.
- Nominal (STEP_CYCLES=1): load 1->0 -> init_ld one cycle, then round_en 10 consecutive cycles with round 1..10, rcon 01,02,04,08,10,20,40,80,1B,36, last_round only on round 10, done high 12 cycles after falling edge and held 50 cycles.
- Re-arm: in DONE raise load -> done low next edge, state=1; drop load -> second full sequence identical to first.
- Abort: raise load at round 5 -> next edge state=1, busy=0, no more round_en; drop load -> fresh run starting rcon 01, done after 12 cycles.
- STEP_CYCLES=3: round_en every third cycle, 10 pulses, done 1+30+1=32 cycles after falling edge; rcon/round stable across each 3-cycle round.
- Integration: with aes core datapath, key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> cyphertext 3925841d02dc09fbdc118597196a0b32 when done rises.
